// File: rtl/poly_ctrl.sv
// poly_ctrl: sequencer for poly_core, running from the full-rate system clock.
//   - Prescaler producing the poly_core enable strobe (poly_enn), one pulse
//     every CLK_DIV clocks.
//   - SKCTL init/flush FSM and AUDCTL 9-bit select. Both are applied only on
//     enable boundaries, so poly_core sees stable controls for a whole period.
//   - RANDOM register read port with a 4-phase req/ack handshake.
//
// Ports:
//   clk, reset_n          system clock, synchronous active-low reset
//   skctl_wr/skctl_data   SKCTL write strobe / data (bits [1:0] used)
//   audctl_wr/audctl_data AUDCTL write strobe / data (bit 7 = 9-bit poly)
//   rnd_req/rnd_ack       RANDOM read handshake (level, 4-phase)
//   rnd_data              captured random byte, valid while rnd_ack = 1
//   poly_rnd              random byte from poly_core
//   poly_enn              enable strobe to poly_core
//   poly_init             init control to poly_core
//   poly_sel9             9-bit poly select to poly_core
//   init_active           1 while the init FSM is in INIT
//
// Optional build macro POLY_CTRL_STEP_EN adds dbg_freeze / dbg_step:
//   freeze stops the prescaler, and each dbg_step rising edge issues one
//   poly_enn pulse. The next cycle is treated as the boundary.

module poly_ctrl #(
  parameter int CLK_DIV   = 16,   // clocks per enable, 2..256
  parameter int FLUSH_LEN = 17    // enables required in INIT before RUN
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       skctl_wr,
  input  logic [7:0] skctl_data,
  input  logic       audctl_wr,
  input  logic [7:0] audctl_data,
  input  logic       rnd_req,
  output logic       rnd_ack,
  output logic [7:0] rnd_data,
  input  logic [7:0] poly_rnd,
  output logic       poly_enn,
  output logic       poly_init,
  output logic       poly_sel9,
  output logic       init_active
`ifdef POLY_CTRL_STEP_EN
  ,
  input  logic       dbg_freeze,
  input  logic       dbg_step
`endif
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int FW = $clog2(FLUSH_LEN + 1);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
  localparam logic [FW-1:0] FLEN = FW'(FLUSH_LEN);

  typedef enum logic       {INIT, RUN}           init_st_t;
  typedef enum logic [1:0] {R_IDLE, R_CAP, R_ACK} rd_st_t;

  init_st_t      in_st;
  rd_st_t        rd_st;
  logic [DW-1:0] div_cnt, div_nxt, cnt_nxt;
  logic          enn_nxt, bnd;
  logic [FW-1:0] flush_cnt;
  logic [1:0]    skmode;
  logic          sel9_pend;

  // Only SKCTL[1:0] and AUDCTL[7] are meaningful.
  logic unused_bits;
  assign unused_bits = ^{skctl_data[7:2], audctl_data[6:0]};

`ifdef POLY_CTRL_STEP_EN
  logic step_q, step_bnd;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      step_q   <= 1'b0;
      step_bnd <= 1'b0;
    end else begin
      step_q   <= dbg_step;
      // The cycle after a stepped pulse acts as the boundary.
      step_bnd <= dbg_freeze & poly_enn;
    end
  end
`endif

  // poly_enn is registered against the next count, so it is high exactly in
  // the cycle where div_cnt == CLK_DIV-1. The boundary is the following cycle.
  always_comb begin
    div_nxt = (div_cnt == LAST) ? '0 : div_cnt + 1'b1;
    cnt_nxt = div_nxt;
    enn_nxt = (div_nxt == LAST);
    bnd     = (div_cnt == '0);
`ifdef POLY_CTRL_STEP_EN
    if (dbg_freeze) begin
      // Parking the counter at 0 means unfreeze resumes from the period start.
      cnt_nxt = '0;
      enn_nxt = dbg_step & ~step_q;
      bnd     = step_bnd;
    end
`endif
  end

  // Prescaler, register capture and init/flush FSM.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      poly_enn  <= 1'b0;
      poly_init <= 1'b1;
      poly_sel9 <= 1'b0;
      sel9_pend <= 1'b0;
      skmode    <= 2'b00;
      flush_cnt <= '0;
      in_st     <= INIT;
    end else begin
      div_cnt  <= cnt_nxt;
      poly_enn <= enn_nxt;
      if (skctl_wr)  skmode    <= skctl_data[1:0];
      if (audctl_wr) sel9_pend <= audctl_data[7];
      if (bnd)       poly_sel9 <= sel9_pend;
      case (in_st)
        INIT: begin
          if (poly_enn && flush_cnt != FLEN) flush_cnt <= flush_cnt + 1'b1;
          // skmode is only examined at the boundary, so a 00 write followed
          // by a nonzero write in the same period causes no transition.
          if (bnd && skmode != 2'b00 && flush_cnt == FLEN) begin
            in_st     <= RUN;
            poly_init <= 1'b0;
          end
        end
        RUN: begin
          if (bnd && skmode == 2'b00) begin
            in_st     <= INIT;
            poly_init <= 1'b1;
            flush_cnt <= '0;
          end
        end
        default: begin
          in_st     <= INIT;
          poly_init <= 1'b1;
          flush_cnt <= '0;
        end
      endcase
    end
  end

  assign init_active = (in_st == INIT);

  // RANDOM read: capture one cycle after the request is seen, then raise
  // ack on the following edge and hold the captured data until req drops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_st    <= R_IDLE;
      rnd_ack  <= 1'b0;
      rnd_data <= 8'h00;
    end else begin
      case (rd_st)
        R_IDLE: if (rnd_req) rd_st <= R_CAP;
        R_CAP: begin
          rnd_data <= poly_rnd;
          rd_st    <= R_ACK;
        end
        R_ACK: begin
          if (rnd_req) rnd_ack <= 1'b1;
          else begin
            rnd_ack <= 1'b0;
            rd_st   <= R_IDLE;
          end
        end
        default: begin
          rnd_ack <= 1'b0;
          rd_st   <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_ctrl.sv
// Self-checking bench for poly_ctrl. The reference model tracks time since
// reset as a plain cycle count and derives enable/boundary positions from it
// arithmetically; the read model tracks how many consecutive edges rnd_req
// has been held high.
module tb_poly_ctrl;

  localparam int CLK_DIV   = 16;
  localparam int FLUSH_LEN = 17;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       skctl_wr, audctl_wr, rnd_req;
  logic [7:0] skctl_data, audctl_data, poly_rnd;
  logic       rnd_ack, poly_enn, poly_init, poly_sel9, init_active;
  logic [7:0] rnd_data;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int         m_t, m_flush, m_run;
  bit         m_init, m_sel9, m_pend;
  logic [1:0] m_sk;
  logic [7:0] m_data;

  always #5 clk = ~clk;

  poly_ctrl #(.CLK_DIV(CLK_DIV), .FLUSH_LEN(FLUSH_LEN)) dut (
    .clk(clk), .reset_n(reset_n),
    .skctl_wr(skctl_wr), .skctl_data(skctl_data),
    .audctl_wr(audctl_wr), .audctl_data(audctl_data),
    .rnd_req(rnd_req), .rnd_ack(rnd_ack), .rnd_data(rnd_data),
    .poly_rnd(poly_rnd), .poly_enn(poly_enn), .poly_init(poly_init),
    .poly_sel9(poly_sel9), .init_active(init_active)
`ifdef POLY_CTRL_STEP_EN
    , .dbg_freeze(1'b0), .dbg_step(1'b0)
`endif
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, m_t);
    end
  endtask

  // Advance the model over the coming edge using the inputs now applied.
  task automatic model_edge();
    bit bnd, en;
    if (!reset_n) begin
      m_t = 0; m_flush = 0; m_run = 0;
      m_init = 1; m_sel9 = 0; m_pend = 0; m_sk = 2'b00; m_data = 8'h00;
    end else begin
      bnd = (m_t % CLK_DIV == 0);
      en  = (m_t % CLK_DIV == CLK_DIV - 1);
      if (m_init && en) m_flush++;
      if (bnd) begin
        m_sel9 = m_pend;
        if (m_init && m_sk != 2'b00 && m_flush >= FLUSH_LEN) m_init = 0;
        else if (!m_init && m_sk == 2'b00) begin
          m_init  = 1;
          m_flush = 0;
        end
      end
      if (skctl_wr)  m_sk   = skctl_data[1:0];
      if (audctl_wr) m_pend = audctl_data[7];
      if (rnd_req) begin
        if (m_run < 3) m_run++;
        if (m_run == 2) m_data = poly_rnd;
      end else m_run = 0;
      m_t++;
    end
  endtask

  task automatic check_all();
    chk("poly_enn",    poly_enn,    (m_t % CLK_DIV == CLK_DIV - 1));
    chk("poly_init",   poly_init,   m_init);
    chk("init_active", init_active, m_init);
    chk("poly_sel9",   poly_sel9,   m_sel9);
    chk("rnd_ack",     rnd_ack,     (m_run >= 3));
    if (m_run >= 3) chk("rnd_data", rnd_data, m_data);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic run_until_mod(input int k);
    while (m_t % CLK_DIV != k) tick();
  endtask

  task automatic wr_skctl(input logic [7:0] d);
    skctl_data = d; skctl_wr = 1'b1;
    tick();
    skctl_wr = 1'b0;
  endtask

  task automatic wr_audctl(input logic [7:0] d);
    audctl_data = d; audctl_wr = 1'b1;
    tick();
    audctl_wr = 1'b0;
  endtask

  initial begin
    int req_left;
    reset_n = 1'b0; skctl_wr = 1'b0; audctl_wr = 1'b0; rnd_req = 1'b0;
    skctl_data = 8'h00; audctl_data = 8'h00; poly_rnd = 8'hFF;

    // Reset state.
    repeat (3) tick();
    chk("rst_rnd_data", rnd_data, 8'h00);

    // Enable cadence after reset, then leave INIT after the 17th enable.
    reset_n = 1'b1;
    while (m_t < 100) begin
      tick();
      if (m_t == 15 || m_t == 31 || m_t == 47) chk("enn_pulse", poly_enn, 1'b1);
      if (m_t == 16) chk("enn_gap", poly_enn, 1'b0);
    end
    wr_skctl(8'h03);
    while (m_t < 272) tick();
    chk("init_hold_at_bnd", poly_init, 1'b1);
    tick();
    chk("init_drop", poly_init, 1'b0);
    chk("run_active", init_active, 1'b0);

    // AUDCTL last-wins within a period, then a lone 9-bit select.
    run_until_mod(2);
    wr_audctl(8'h80);
    run_until_mod(6);
    wr_audctl(8'h00);
    run_until_mod(1);
    chk("sel9_lastwins", poly_sel9, 1'b0);
    run_until_mod(3);
    wr_audctl(8'h80);
    run_until_mod(0);
    chk("sel9_not_early", poly_sel9, 1'b0);
    tick();
    chk("sel9_set", poly_sel9, 1'b1);

    // Directed RANDOM read.
    poly_rnd = 8'hA5; rnd_req = 1'b1;
    tick(); chk("ack_lat0", rnd_ack, 1'b0);
    tick(); chk("ack_lat1", rnd_ack, 1'b0);
    tick(); chk("ack_up", rnd_ack, 1'b1); chk("rd_a5", rnd_data, 8'hA5);
    poly_rnd = 8'h3C;
    tick(); tick();
    chk("rd_hold", rnd_data, 8'hA5);
    rnd_req = 1'b0;
    tick(); chk("ack_drop", rnd_ack, 1'b0);

    // SKCTL 00 then nonzero in one period: no transition; then a real 00.
    run_until_mod(5);
    wr_skctl(8'h00);
    run_until_mod(9);
    wr_skctl(8'h02);
    run_until_mod(1);
    chk("sk_glitch_run", poly_init, 1'b0);
    run_until_mod(5);
    wr_skctl(8'h00);
    run_until_mod(0);
    chk("sk00_not_early", poly_init, 1'b0);
    tick();
    chk("sk00_init", poly_init, 1'b1);
    chk("sk00_active", init_active, 1'b1);

    // Randomized traffic: register writes, reads and changing poly_rnd.
    req_left = 2;
    for (int i = 0; i < 3000; i++) begin
      poly_rnd = 8'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        skctl_wr   = 1'b1;
        skctl_data = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      end
      if ($urandom_range(0, 39) == 0) begin
        audctl_wr   = 1'b1;
        audctl_data = 8'($urandom);
      end
      if (req_left == 0) begin
        rnd_req  = ~rnd_req;
        req_left = rnd_req ? $urandom_range(3, 8) : $urandom_range(1, 4);
      end
      req_left--;
      tick();
      skctl_wr = 1'b0; audctl_wr = 1'b0;
    end
    rnd_req = 1'b0;
    repeat (2) tick();

    // Reset while in RUN with an ack held.
    wr_skctl(8'h03);
    for (int i = 0; i < 400 && m_init; i++) tick();
    chk("reach_run", init_active, 1'b0);
    run_until_mod(7);
    rnd_req = 1'b1;
    repeat (3) tick();
    chk("pre_rst_ack", rnd_ack, 1'b1);
    reset_n = 1'b0;
    tick();
    chk("rst_ack", rnd_ack, 1'b0);
    chk("rst_init", poly_init, 1'b1);
    chk("rst_enn", poly_enn, 1'b0);
    chk("rst_active", init_active, 1'b1);
    reset_n = 1'b1; rnd_req = 1'b0;
    // Prescaler phase restarts from zero: pulse again at cycle 15.
    repeat (15) tick();
    chk("rst_phase", poly_enn, 1'b1);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/poly_ctrl.md
Name: poly_ctrl

Overview:
Controller that sequences the poly_core polynomial block from the full-rate system clock.
- Generates the poly_core clock-enable strobe (the 1.79 MHz equivalent) from a programmable prescaler.
- Owns the SKCTL-driven init/flush state machine and the AUDCTL 9/17-bit select, applying both only on enable boundaries.
- Serves CPU RANDOM-register reads through a 4-phase req/ack handshake.
- Sits between the register-decode logic and poly_core.

Parameters:
CLK_DIV, 16, system clocks per poly_core enable pulse; legal range 2..256.
FLUSH_LEN, 17, enable pulses that must be issued while init is held before leaving INIT (flushes the longest LFSR).

Ports:
clk  in  1  system clock; all logic on rising edge.
reset_n  in  1  synchronous, active-low reset.
skctl_wr  in  1  one-cycle write strobe for SKCTL.
skctl_data  in  8  SKCTL write data; only bits [1:0] used.
audctl_wr  in  1  one-cycle write strobe for AUDCTL.
audctl_data  in  8  AUDCTL write data; only bit 7 used (1 = 9-bit poly).
rnd_req  in  1  RANDOM read request, level, 4-phase.
rnd_ack  out  1  RANDOM read acknowledge.
rnd_data  out  8  captured random byte; valid while rnd_ack = 1.
poly_rnd  in  8  rndNum from poly_core.
poly_enn  out  1  enable strobe to poly_core enn.
poly_init  out  1  to poly_core Init.
poly_sel9  out  1  to poly_core sel9bitPoly.
init_active  out  1  status: 1 while the FSM is in INIT.

Behaviour:
Clock and reset:
- Single clock, clk.
- reset_n is synchronous and active-low; sampled on the clk rising edge.

Reset values:
- div_cnt = 0, poly_enn = 0, poly_init = 1, poly_sel9 = 0, sel9_pend = 0, skmode = 2'b00.
- Init FSM = INIT, flush_cnt = 0.
- Read FSM = R_IDLE, rnd_ack = 0, rnd_data = 8'h00.

Prescaler:
- div_cnt counts 0..CLK_DIV-1 and wraps.
- poly_enn is registered; it is 1 for exactly one clk whenever div_cnt == CLK_DIV-1, otherwise 0.
- Free-running in every state, including INIT, because shifting is required to flush.

Boundary:
- "boundary" means the cycle in which div_cnt == 0.
- poly_init and poly_sel9 update only on a boundary, so each is constant across a whole enable period.

Register capture:
- skctl_wr: skmode <= skctl_data[1:0] immediately.
- audctl_wr: sel9_pend <= audctl_data[7].
- On each boundary: poly_sel9 <= sel9_pend.
- Writes are last-wins: repeated writes within one period keep only the last value.

Init FSM:
- INIT: poly_init = 1; flush_cnt increments on each poly_enn and saturates at FLUSH_LEN.
- INIT -> RUN when, on a boundary, skmode != 2'b00 and flush_cnt == FLUSH_LEN. poly_init <= 0 in that same cycle.
- RUN: poly_init = 0.
- RUN -> INIT on the first boundary with skmode == 2'b00; poly_init <= 1 and flush_cnt <= 0.
- A write of 00 followed by a nonzero write within the same period: no transition.
- init_active = (state == INIT).

Read FSM (4-phase):
- R_IDLE: rnd_req = 1 -> R_CAP.
- R_CAP: rnd_data <= poly_rnd -> R_ACK.
- R_ACK: rnd_ack = 1; hold rnd_data until rnd_req = 0, then rnd_ack <= 0 -> R_IDLE.
- Latency: req first seen high at edge N gives rnd_ack high after edge N+2.
- Reads are served in all init states. During INIT the poly_core output is 8'hFF after flushing; no special case.
- SKCTL/AUDCTL writes during a read do not disturb the read.

Reset mid-operation:
- All state returns to reset values on the next edge, including the prescaler phase.
- A pending ack is dropped.

Optional Feature:
POLY_CTRL_STEP_EN
- Defined: adds inputs dbg_freeze (1 bit) and dbg_step (1 bit).
  - While dbg_freeze = 1, the prescaler holds and the automatic poly_enn is suppressed.
  - Each rising edge of dbg_step (edge-detected internally) produces exactly one poly_enn pulse, which counts as an enable for flush_cnt.
  - Boundary updates still apply on the cycle after the step pulse.
  - Deasserting dbg_freeze resumes the count from div_cnt = 0.
- Undefined: ports absent; behaviour as above.

Test Plan:
- Reset, CLK_DIV=16 -> poly_enn pulses on cycles 15, 31, 47; poly_init = 1; init_active = 1; poly_sel9 = 0.
- Write SKCTL=8'h03 before the 17th enable -> poly_init stays 1 until the first boundary after enable #17, then drops to 0 on that boundary; init_active = 0.
- In RUN, write SKCTL=8'h00 mid-period -> poly_init = 1 at the next boundary, not before; flush_cnt restarts at 0.
- Write AUDCTL=8'h80 then 8'h00 within one period -> poly_sel9 remains 0; write 8'h80 alone -> poly_sel9 = 1 at the next boundary.
- Raise rnd_req with poly_rnd = 8'hA5 -> rnd_ack = 1 two edges later with rnd_data = 8'hA5. Change poly_rnd to 8'h3C while the ack is held -> rnd_data stays 8'hA5. Drop rnd_req -> rnd_ack = 0 next edge.
- Assert reset_n = 0 while in R_ACK and RUN -> next edge: rnd_ack = 0, poly_init = 1, div_cnt = 0, poly_enn = 0.
